// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back (P) has fixed priority over the MDU (M),
// with a starvation counter that forces an M grant. Optional build macro: WB_ZERO_DROP_EN.
module regs_wb_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    input  logic [ADDR_W-1:0] p_waddr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_ready,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_waddr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              conflict,
    output logic              starve_force
);

    logic [7:0] starve_cnt;
    logic       p_zero;
    logic       m_zero;
    logic       force_m;
    logic       gm;
    logic       gp;
    logic       m_wr;
    logic       p_wr;

`ifdef WB_ZERO_DROP_EN
    // Zero-address requests are accepted and dropped, so they never compete for the write slot
    assign p_zero = p_valid && (p_waddr == '0);
    assign m_zero = m_valid && (m_waddr == '0);
`else
    assign p_zero = 1'b0;
    assign m_zero = 1'b0;
`endif

    assign force_m = m_valid && !m_zero && (starve_cnt >= 8'(STARVE_MAX));

    assign p_ready = rst_n && (!force_m || p_zero);
    assign m_ready = rst_n && m_valid && (m_zero || !(p_valid && !p_zero) || force_m);

    assign gm   = m_valid && m_ready;
    assign m_wr = gm && !m_zero;
    assign gp   = p_valid && p_ready && !m_wr;
    assign p_wr = gp && !p_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            conflict     <= 1'b0;
            starve_force <= 1'b0;
            starve_cnt   <= 8'd0;
        end else begin
            if (m_wr) begin
                rf_we    <= 1'b1;
                rf_waddr <= m_waddr;
                rf_wdata <= m_wdata;
            end else if (p_wr) begin
                rf_we    <= 1'b1;
                rf_waddr <= p_waddr;
                rf_wdata <= p_wdata;
            end else begin
                rf_we <= 1'b0;
            end

            conflict     <= p_valid && m_valid && !p_zero && !m_zero;
            starve_force <= m_wr && force_m;

            // Saturates so a very long wait can never wrap back below the threshold
            if (!m_valid || gm) begin
                starve_cnt <= 8'd0;
            end else if (starve_cnt != 8'd255) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed self-checking bench for regs_wb_arbiter (STARVE_MAX=4), with hand-computed expectations.
module tb_regs_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_valid;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        p_ready;
    logic        m_valid;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        conflict;
    logic        starve_force;

    int vec_count = 0;
    int err_count = 0;

    regs_wb_arbiter #(
        .ADDR_W(5),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .p_valid(p_valid),
        .p_waddr(p_waddr),
        .p_wdata(p_wdata),
        .p_ready(p_ready),
        .m_valid(m_valid),
        .m_waddr(m_waddr),
        .m_wdata(m_wdata),
        .m_ready(m_ready),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .conflict(conflict),
        .starve_force(starve_force)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md);
        p_valid = pv;
        p_waddr = pa;
        p_wdata = pd;
        m_valid = mv;
        m_waddr = ma;
        m_wdata = md;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both requesters active: readies must stay low
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd3, 32'h0, 1'b1, 5'd9, 32'h0);
        checkOutput("rst_p_ready", 32'(p_ready), 32'd0);
        checkOutput("rst_m_ready", 32'(m_ready), 32'd0);
        tick;
        tick;
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("rst_rf_wdata", rf_wdata, 32'd0);
        checkOutput("rst_conflict", 32'(conflict), 32'd0);
        checkOutput("rst_starve_force", 32'(starve_force), 32'd0);

        // Single P write, then idle holds address/data
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
        checkOutput("p1_p_ready", 32'(p_ready), 32'd1);
        checkOutput("p1_m_ready", 32'(m_ready), 32'd0);
        tick;
        checkOutput("p1_rf_we", 32'(rf_we), 32'd1);
        checkOutput("p1_rf_waddr", 32'(rf_waddr), 32'd3);
        checkOutput("p1_rf_wdata", rf_wdata, 32'h11);
        checkOutput("p1_conflict", 32'(conflict), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick;
        checkOutput("idle_rf_we", 32'(rf_we), 32'd0);
        checkOutput("idle_rf_waddr_hold", 32'(rf_waddr), 32'd3);
        checkOutput("idle_rf_wdata_hold", rf_wdata, 32'h11);

        // Lone M request granted immediately
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hABCD);
        checkOutput("m1_m_ready", 32'(m_ready), 32'd1);
        checkOutput("m1_p_ready", 32'(p_ready), 32'd1);
        tick;
        checkOutput("m1_rf_we", 32'(rf_we), 32'd1);
        checkOutput("m1_rf_waddr", 32'(rf_waddr), 32'd7);
        checkOutput("m1_rf_wdata", rf_wdata, 32'hABCD);
        checkOutput("m1_starve_force", 32'(starve_force), 32'd0);

        // Sustained P traffic starves M for four cycles, fifth cycle forces M
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 5'(k), 32'h100 + 32'(k), 1'b1, 5'd9, 32'h99);
            checkOutput("st_p_ready", 32'(p_ready), 32'd1);
            checkOutput("st_m_ready", 32'(m_ready), 32'd0);
            tick;
            checkOutput("st_rf_waddr", 32'(rf_waddr), 32'(k));
            checkOutput("st_conflict", 32'(conflict), 32'd1);
            checkOutput("st_starve_force", 32'(starve_force), 32'd0);
        end
        applyStimulus(1'b1, 5'd5, 32'h105, 1'b1, 5'd9, 32'h99);
        checkOutput("force_p_ready", 32'(p_ready), 32'd0);
        checkOutput("force_m_ready", 32'(m_ready), 32'd1);
        tick;
        checkOutput("force_rf_waddr", 32'(rf_waddr), 32'd9);
        checkOutput("force_rf_wdata", rf_wdata, 32'h99);
        checkOutput("force_starve_force", 32'(starve_force), 32'd1);
        applyStimulus(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'h0);
        checkOutput("resume_p_ready", 32'(p_ready), 32'd1);
        tick;
        checkOutput("resume_rf_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("resume_starve_force", 32'(starve_force), 32'd0);

        // Partial wait, then P drops and M wins without forcing
        for (int c = 1; c <= 2; c++) begin
            applyStimulus(1'b1, 5'd2, 32'h200, 1'b1, 5'd10, 32'hA0);
            checkOutput("part_m_ready", 32'(m_ready), 32'd0);
            tick;
        end
        applyStimulus(1'b0, 5'd2, 32'h200, 1'b1, 5'd10, 32'hA0);
        checkOutput("part_rel_m_ready", 32'(m_ready), 32'd1);
        tick;
        checkOutput("part_rf_waddr", 32'(rf_waddr), 32'd10);
        checkOutput("part_starve_force", 32'(starve_force), 32'd0);

        // Counter restarted from zero: next M needs a full four waiting cycles
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b1, 5'd6, 32'h600, 1'b1, 5'd11, 32'hB0);
            checkOutput("clr_m_ready", 32'(m_ready), (c == 5) ? 32'd1 : 32'd0);
            tick;
        end
        checkOutput("clr_rf_waddr", 32'(rf_waddr), 32'd11);
        checkOutput("clr_starve_force", 32'(starve_force), 32'd1);

        // Reset mid-wait discards starvation history
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 5'd4, 32'h400, 1'b1, 5'd12, 32'hC0);
            tick;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_p_ready", 32'(p_ready), 32'd0);
        checkOutput("mid_rst_m_ready", 32'(m_ready), 32'd0);
        tick;
        checkOutput("mid_rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("mid_rst_conflict", 32'(conflict), 32'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b1, 5'd4, 32'h400, 1'b1, 5'd12, 32'hC0);
            checkOutput("post_rst_m_ready", 32'(m_ready), (c == 5) ? 32'd1 : 32'd0);
            tick;
        end
        checkOutput("post_rst_rf_waddr", 32'(rf_waddr), 32'd12);
        checkOutput("post_rst_starve_force", 32'(starve_force), 32'd1);

        // P to register 0 alongside M to register 5
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick;
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b1, 5'd5, 32'h66);
        checkOutput("z_p_ready", 32'(p_ready), 32'd1);
`ifdef WB_ZERO_DROP_EN
        checkOutput("z_m_ready", 32'(m_ready), 32'd1);
        tick;
        checkOutput("z_rf_we", 32'(rf_we), 32'd1);
        checkOutput("z_rf_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("z_rf_wdata", rf_wdata, 32'h66);
        checkOutput("z_conflict", 32'(conflict), 32'd0);
`else
        checkOutput("z_m_ready", 32'(m_ready), 32'd0);
        tick;
        checkOutput("z_rf_we", 32'(rf_we), 32'd1);
        checkOutput("z_rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("z_rf_wdata", rf_wdata, 32'h55);
        checkOutput("z_conflict", 32'(conflict), 32'd1);
`endif
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick;
        checkOutput("end_rf_we", 32'(rf_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order pipeline write-back stage (P);
  - the multi-cycle multiply/divide unit (M).
- Sits between those requesters and the register file write inputs (we/waddr/wdata).
- Arbitration is fixed priority to P, with a starvation counter that forces an M grant.
- One registered write per cycle.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
STARVE_MAX, 4, consecutive cycles M may wait with m_valid high before a grant is forced; legal range 1..255

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
p_valid  in  1  pipeline write request
p_waddr  in  ADDR_W  pipeline destination register
p_wdata  in  DATA_W  pipeline write data
p_ready  out  1  pipeline request accepted this cycle when p_valid&&p_ready
m_valid  in  1  MDU write request; held stable until accepted
m_waddr  in  ADDR_W  MDU destination register
m_wdata  in  DATA_W  MDU write data
m_ready  out  1  MDU request accepted this cycle when m_valid&&m_ready
rf_we  out  1  register file write enable
rf_waddr  out  ADDR_W  register file write address
rf_wdata  out  DATA_W  register file write data
conflict  out  1  registered pulse: both requesters were valid in the previous cycle
starve_force  out  1  registered pulse: the previous cycle's M grant was forced by the starvation counter

Behaviour:
- Reset (rst_n low at a clk edge): rf_we=0, rf_waddr=0, rf_wdata=0, conflict=0, starve_force=0, starve counter=0.
  - p_ready and m_ready are forced 0 while rst_n is low.
  - Reset mid-wait discards starvation history; no write issues in the cycle after reset.
- Starvation hit: force = m_valid && (starve_cnt >= STARVE_MAX).
- Ready generation (combinational):
  - p_ready = rst_n && !force.
  - m_ready = rst_n && m_valid && (!p_valid || force).
  - p_ready does not depend on p_valid.
- Grant selection:
  - gm = m_valid && m_ready.
  - gp = p_valid && p_ready && !gm.
  - At most one grant per cycle.
- Write output, 1-cycle latency, registered:
  - On gp: rf_we<=1, rf_waddr<=p_waddr, rf_wdata<=p_wdata.
  - On gm: rf_we<=1, rf_waddr<=m_waddr, rf_wdata<=m_wdata.
  - With no grant: rf_we<=0; rf_waddr and rf_wdata hold their previous values.
- Starvation counter (8 bits, saturating at 255):
  - Cleared on gm or when !m_valid.
  - Incremented when m_valid && !gm.
  - After a forced grant, P regains priority.
  - Worst-case M wait is STARVE_MAX+1 cycles.
- conflict <= p_valid && m_valid. starve_force <= gm && force.
- Ordering: if P and M target the same register, the later grant wins. Ordering correctness is an upstream (hazard unit) responsibility; the arbiter does not reorder or merge.
- A P request refused by force must be held by the pipeline (stall). The arbiter holds no buffer.
- Address 0 requests are granted and written like any other. The register file ignores waddr=0.

Optional Feature:
- Macro WB_ZERO_DROP_EN.
- Defined:
  - A valid request with waddr==0 is accepted (its ready is 1 regardless of priority) and consumes no write slot: rf_we stays 0 for it.
  - Such a request does not count as a conflict.
  - A zero-address M request clears the starvation counter.
  - If both requests target address 0, both are accepted in the same cycle.
- Undefined: behaviour exactly as in Behaviour above.

Test Plan:
- Reset, then p_valid=1, p_waddr=3, p_wdata=0x11 for 1 cycle -> p_ready=1; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x11; following cycle rf_we=0.
- m_valid=1, m_waddr=7, m_wdata=0xABCD, p_valid=0 -> m_ready=1 same cycle; next cycle rf_we=1, rf_waddr=7; starve_force=0.
- p_valid held 1 (addr 1..n), m_valid=1 (addr 9), STARVE_MAX=4 -> P granted 4 cycles with conflict=1; 5th cycle p_ready=0, m_ready=1; next cycle rf_waddr=9, starve_force=1; then P resumes.
- Starvation partial then release: m_valid high 2 cycles under P traffic, p_valid drops -> M granted on cycle 3 with starve_force=0; counter reads 0 afterwards.
- rst_n low for 1 cycle while M has waited 3 cycles (STARVE_MAX=4) -> rf_we=0 next cycle; after release M needs a full 4 more waiting cycles before it is forced.
- WB_ZERO_DROP_EN defined: p_valid with p_waddr=0 and m_valid with m_waddr=5 in the same cycle -> both ready=1; next cycle rf_we=1, rf_waddr=5, conflict=0. Undefined build: only P granted, and rf_waddr=0.
